alu_issue: RTL and testbench

Issue stage that drives the EX-stage ALU. It decodes RV32 opcode/funct fields into the 3-bit ALU control code, selects the second operand (register or immediate), and holds the result in a one-entry ID/EX slot with a valid/ready handshake. MUL is treated as multi-cycle: the slot holds MUL operands stable for `MUL_LAT` cycles before the op is declared done. It sits between the decoder/register file and the combinational ALU.

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu_ctrl_decode.sv | 53 +++++
 rtl/alu_issue.sv | 139 +++++++++++++
 tb/tb_alu_issue.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the EX-stage ALU and its issue slot: control codes,
// opcode/funct7 constants, issue FSM states and the decode result bundle.
package alu_pkg;

   localparam logic [2:0] ALU_AND  = 3'b000;
   localparam logic [2:0] ALU_XOR  = 3'b001;
   localparam logic [2:0] ALU_SLL  = 3'b010;
   localparam logic [2:0] ALU_ADD  = 3'b011;
   localparam logic [2:0] ALU_SUB  = 3'b100;
   localparam logic [2:0] ALU_MUL  = 3'b101;
   localparam logic [2:0] ALU_ADDI = 3'b110;
   localparam logic [2:0] ALU_SRAI = 3'b111;

   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   typedef enum logic [1:0] {
      ST_EMPTY    = 2'b00,
      ST_FULL     = 2'b01,
      ST_MUL_WAIT = 2'b10
   } issue_state_t;

   typedef struct packed {
      logic [2:0] ctrl;
      logic       use_imm;
      logic       illegal;
   } decode_t;

   function automatic logic is_mul(input logic [2:0] ctrl);
      return (ctrl == ALU_MUL);
   endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational RV32 field decode into ALU control code, operand-2 select and
// an illegal flag. Unknown encodings fall back to ADD on rs2.
module alu_ctrl_decode
   import alu_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   output decode_t    dec
);

   // Field decode; every path assigns all three result fields.
   always_comb begin
      dec.ctrl    = ALU_ADD;
      dec.use_imm = 1'b0;
      dec.illegal = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            case ({funct7, funct3})
               {F7_BASE,   3'b111}: dec.ctrl = ALU_AND;
               {F7_BASE,   3'b100}: dec.ctrl = ALU_XOR;
               {F7_BASE,   3'b001}: dec.ctrl = ALU_SLL;
               {F7_BASE,   3'b000}: dec.ctrl = ALU_ADD;
               {F7_ALT,    3'b000}: dec.ctrl = ALU_SUB;
               {F7_MULDIV, 3'b000}: dec.ctrl = ALU_MUL;
               default:             dec.illegal = 1'b1;
            endcase
         end
         OP_ITYPE: begin
            if (funct3 == 3'b000) begin
               dec.ctrl    = ALU_ADDI;
               dec.use_imm = 1'b1;
            end else if (funct3 == 3'b101 && funct7 == F7_ALT) begin
               dec.ctrl    = ALU_SRAI;
               dec.use_imm = 1'b1;
            end else begin
               dec.illegal = 1'b1;
            end
         end
         OP_LOAD, OP_STORE: begin
            dec.ctrl    = ALU_ADD;
            dec.use_imm = 1'b1;
         end
         OP_BRANCH: begin
            dec.ctrl = ALU_SUB;
         end
         default: begin
            dec.illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/alu_issue.sv
// One-entry ID/EX issue slot in front of the ALU. Holds decoded control and
// operands, stretches MUL for MUL_LAT cycles, valid/ready on both sides.
module alu_issue
   import alu_pkg::*;
#(
   parameter int unsigned MUL_LAT = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        valid_i,
   output logic        ready_o,
   input  logic [31:0] instr_i,
   input  logic [31:0] rs1_data_i,
   input  logic [31:0] rs2_data_i,
   input  logic [31:0] imm_i,
   input  logic        flush_i,
   input  logic        ready_i,
   output logic        valid_o,
   output logic        done_o,
   output logic [2:0]  ALUCtrl_o,
   output logic [31:0] data1_o,
   output logic [31:0] data2_o,
   output logic        illegal_o
);

   localparam logic [3:0] MUL_LOAD = 4'(MUL_LAT - 1);
   localparam logic       MUL_MULTI = (MUL_LAT > 1);

   issue_state_t state_r, state_nxt_s;
   logic [3:0]   cnt_r, cnt_nxt_s;
   decode_t      dec_s;
   logic         accept_s;
   logic         valid_r, done_r;
   logic [2:0]   ctrl_r;
   logic [31:0]  data1_r, data2_r;
   logic         illegal_r;
   logic         unused_instr_s;

   assign unused_instr_s = ^{instr_i[24:15], instr_i[11:7]};

   alu_ctrl_decode u_decode (
      .opcode (instr_i[6:0]),
      .funct3 (instr_i[14:12]),
      .funct7 (instr_i[31:25]),
      .dec    (dec_s)
   );

   // Upstream handshake; flush kills any instruction offered in the same cycle.
   always_comb begin
      ready_o  = (state_r == ST_EMPTY) || ((state_r == ST_FULL) && ready_i);
      accept_s = valid_i && ready_o && !flush_i;
   end

   // Next-state and MUL counter logic.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      if (flush_i) begin
         state_nxt_s = ST_EMPTY;
         cnt_nxt_s   = 4'd0;
      end else if (accept_s) begin
         if (is_mul(dec_s.ctrl) && MUL_MULTI) begin
            state_nxt_s = ST_MUL_WAIT;
            cnt_nxt_s   = MUL_LOAD;
         end else begin
            state_nxt_s = ST_FULL;
            cnt_nxt_s   = 4'd0;
         end
      end else begin
         case (state_r)
            ST_EMPTY: begin
               state_nxt_s = ST_EMPTY;
            end
            ST_FULL: begin
               if (ready_i) begin
                  state_nxt_s = ST_EMPTY;
               end else begin
                  state_nxt_s = ST_FULL;
               end
            end
            ST_MUL_WAIT: begin
               if (cnt_r <= 4'd1) begin
                  state_nxt_s = ST_FULL;
                  cnt_nxt_s   = 4'd0;
               end else begin
                  cnt_nxt_s   = cnt_r - 4'd1;
               end
            end
            default: begin
               state_nxt_s = ST_EMPTY;
               cnt_nxt_s   = 4'd0;
            end
         endcase
      end
   end

   // State, counter and registered status outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r <= ST_EMPTY;
         cnt_r   <= 4'd0;
         valid_r <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         valid_r <= (state_nxt_s != ST_EMPTY);
         done_r  <= (state_nxt_s == ST_FULL);
      end
   end

   // Slot fields load only on accept and otherwise hold.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ctrl_r    <= ALU_AND;
         data1_r   <= 32'd0;
         data2_r   <= 32'd0;
         illegal_r <= 1'b0;
      end else if (accept_s) begin
         ctrl_r    <= dec_s.ctrl;
         data1_r   <= rs1_data_i;
         data2_r   <= dec_s.use_imm ? imm_i : rs2_data_i;
         illegal_r <= dec_s.illegal;
      end else begin
         ctrl_r    <= ctrl_r;
         data1_r   <= data1_r;
         data2_r   <= data2_r;
         illegal_r <= illegal_r;
      end
   end

   assign valid_o   = valid_r;
   assign done_o    = done_r;
   assign ALUCtrl_o = ctrl_r;
   assign data1_o   = data1_r;
   assign data2_o   = data2_r;
   assign illegal_o = illegal_r;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with MUL_LAT=3; expected slot contents are
// queued when an instruction is accepted and compared when it completes.
module tb_alu_issue;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        valid_i = 1'b0;
   logic        ready_o;
   logic [31:0] instr_i = 32'd0;
   logic [31:0] rs1_data_i = 32'd0;
   logic [31:0] rs2_data_i = 32'd0;
   logic [31:0] imm_i = 32'd0;
   logic        flush_i = 1'b0;
   logic        ready_i = 1'b1;
   logic        valid_o;
   logic        done_o;
   logic [2:0]  ALUCtrl_o;
   logic [31:0] data1_o;
   logic [31:0] data2_o;
   logic        illegal_o;

   typedef struct packed {
      logic [2:0]  ctrl;
      logic [31:0] d1;
      logic [31:0] d2;
      logic        ill;
   } exp_t;

   exp_t sb[$];
   int   pass_cnt = 0;
   int   total_cnt = 0;
   int   fail_cnt = 0;

   alu_issue #(.MUL_LAT(3)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .valid_i    (valid_i),
      .ready_o    (ready_o),
      .instr_i    (instr_i),
      .rs1_data_i (rs1_data_i),
      .rs2_data_i (rs2_data_i),
      .imm_i      (imm_i),
      .flush_i    (flush_i),
      .ready_i    (ready_i),
      .valid_o    (valid_o),
      .done_o     (done_o),
      .ALUCtrl_o  (ALUCtrl_o),
      .data1_o    (data1_o),
      .data2_o    (data2_o),
      .illegal_o  (illegal_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3,
                                       input logic [6:0] op);
      return {f7, 5'd3, 5'd2, f3, 5'd1, op};
   endfunction

   function automatic exp_t mk(input logic [2:0] c, input logic [31:0] a,
                               input logic [31:0] b, input logic i);
      exp_t e;
      e.ctrl = c; e.d1 = a; e.d2 = b; e.ill = i;
      return e;
   endfunction

   task automatic drive(input logic [31:0] ins, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [31:0] im);
      instr_i = ins; rs1_data_i = r1; rs2_data_i = r2; imm_i = im;
      valid_i = 1'b1;
   endtask

   task automatic issue(input string tag, input logic [31:0] ins, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [31:0] im, input exp_t e);
      int n = 0;
      drive(ins, r1, r2, im);
      while (!ready_o && n < 20) begin tick(); n++; end
      chk({tag, "_ready"}, {31'd0, ready_o}, 32'd1);
      sb.push_back(e);
      tick();
      valid_i = 1'b0;
   endtask

   task automatic cmp_front(input string tag);
      chk({tag, "_sb"}, sb.size(), 32'd1);
      if (sb.size() > 0) begin
         chk({tag, "_ctrl"}, {29'd0, ALUCtrl_o}, {29'd0, sb[0].ctrl});
         chk({tag, "_d1"}, data1_o, sb[0].d1);
         chk({tag, "_d2"}, data2_o, sb[0].d2);
         chk({tag, "_ill"}, {31'd0, illegal_o}, {31'd0, sb[0].ill});
      end
   endtask

   task automatic retire(input string tag);
      int n = 0;
      ready_i = 1'b1;
      while (!done_o && n < 20) begin tick(); n++; end
      chk({tag, "_done"}, {31'd0, done_o}, 32'd1);
      cmp_front(tag);
      if (sb.size() > 0) void'(sb.pop_front());
      tick();
   endtask

   initial begin
      // Reset state.
      tick(); tick();
      chk("rst_valid", {31'd0, valid_o}, 32'd0);
      chk("rst_done", {31'd0, done_o}, 32'd0);
      chk("rst_ctrl", {29'd0, ALUCtrl_o}, 32'd0);
      chk("rst_d1", data1_o, 32'd0);
      chk("rst_d2", data2_o, 32'd0);
      chk("rst_ill", {31'd0, illegal_o}, 32'd0);
      rst_i = 1'b0;
      tick();
      chk("rst_ready", {31'd0, ready_o}, 32'd1);

      // add: done in the first cycle after accept.
      issue("add", enc(7'b0000000, 3'b000, 7'b0110011), 32'd5, 32'd7, 32'hDEAD,
            mk(3'b011, 32'd5, 32'd7, 1'b0));
      chk("add_done_n1", {31'd0, done_o}, 32'd1);
      retire("add");
      chk("add_empty", {31'd0, valid_o}, 32'd0);

      issue("srai", enc(7'b0100000, 3'b101, 7'b0010011), 32'h80000010, 32'd9, 32'h403,
            mk(3'b111, 32'h80000010, 32'h403, 1'b0));
      retire("srai");
      issue("sub", enc(7'b0100000, 3'b000, 7'b0110011), 32'd10, 32'd3, 32'hBEEF,
            mk(3'b100, 32'd10, 32'd3, 1'b0));
      retire("sub");
      issue("ill", enc(7'b0000000, 3'b000, 7'b1111111), 32'd1, 32'd4, 32'h55,
            mk(3'b011, 32'd1, 32'd4, 1'b1));
      retire("ill");
      issue("xor", enc(7'b0000000, 3'b100, 7'b0110011), 32'd12, 32'd13, 32'h66,
            mk(3'b001, 32'd12, 32'd13, 1'b0));
      retire("xor");
      issue("load", enc(7'b0000000, 3'b010, 7'b0000011), 32'h100, 32'd2, 32'h24,
            mk(3'b011, 32'h100, 32'h24, 1'b0));
      retire("load");
      issue("beq", enc(7'b0000000, 3'b000, 7'b1100011), 32'd8, 32'd8, 32'h40,
            mk(3'b100, 32'd8, 32'd8, 1'b0));
      retire("beq");

      // MUL latency 3: two wait cycles, done in the third.
      issue("mul", enc(7'b0000001, 3'b000, 7'b0110011), 32'd6, 32'd7, 32'h77,
            mk(3'b101, 32'd6, 32'd7, 1'b0));
      for (int c = 1; c <= 2; c++) begin
         chk($sformatf("mul_c%0d_valid", c), {31'd0, valid_o}, 32'd1);
         chk($sformatf("mul_c%0d_done", c), {31'd0, done_o}, 32'd0);
         chk($sformatf("mul_c%0d_ready", c), {31'd0, ready_o}, 32'd0);
         cmp_front($sformatf("mul_c%0d", c));
         tick();
      end
      chk("mul_c3_done", {31'd0, done_o}, 32'd1);
      retire("mul");

      // Backpressure: first add held for 4 cycles, second enters with no bubble.
      ready_i = 1'b0;
      issue("bpA", enc(7'b0000000, 3'b000, 7'b0110011), 32'd1, 32'd2, 32'h11,
            mk(3'b011, 32'd1, 32'd2, 1'b0));
      drive(enc(7'b0000000, 3'b111, 7'b0110011), 32'd3, 32'd4, 32'h22);
      for (int c = 0; c < 4; c++) begin
         chk($sformatf("bp%0d_ready", c), {31'd0, ready_o}, 32'd0);
         chk($sformatf("bp%0d_done", c), {31'd0, done_o}, 32'd1);
         cmp_front($sformatf("bp%0d", c));
         tick();
      end
      ready_i = 1'b1;
      #1;
      chk("bp_ready_rise", {31'd0, ready_o}, 32'd1);
      void'(sb.pop_front());
      sb.push_back(mk(3'b000, 32'd3, 32'd4, 1'b0));
      tick();
      valid_i = 1'b0;
      chk("bpB_done", {31'd0, done_o}, 32'd1);
      retire("bpB");

      // Flush beats a simultaneous accept.
      issue("flC", enc(7'b0000000, 3'b000, 7'b0110011), 32'd9, 32'd8, 32'h33,
            mk(3'b011, 32'd9, 32'd8, 1'b0));
      drive(enc(7'b0100000, 3'b000, 7'b0110011), 32'd20, 32'd21, 32'h44);
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      valid_i = 1'b0;
      chk("fl_valid", {31'd0, valid_o}, 32'd0);
      chk("fl_done", {31'd0, done_o}, 32'd0);
      chk("fl_dropped_d1", data1_o, sb[0].d1);
      void'(sb.pop_front());
      tick();
      chk("fl_valid2", {31'd0, valid_o}, 32'd0);

      // Reset one cycle after a MUL accept.
      issue("rmul", enc(7'b0000001, 3'b000, 7'b0110011), 32'd2, 32'd3, 32'h88,
            mk(3'b101, 32'd2, 32'd3, 1'b0));
      tick();
      rst_i = 1'b1;
      #1;
      chk("rm_valid", {31'd0, valid_o}, 32'd0);
      chk("rm_done", {31'd0, done_o}, 32'd0);
      chk("rm_ctrl", {29'd0, ALUCtrl_o}, 32'd0);
      chk("rm_d1", data1_o, 32'd0);
      chk("rm_d2", data2_o, 32'd0);
      sb.delete();
      tick();
      rst_i = 1'b0;
      tick();
      chk("rm_ready", {31'd0, ready_o}, 32'd1);
      for (int c = 0; c < 4; c++) begin
         chk($sformatf("rm_nodone%0d", c), {31'd0, done_o}, 32'd0);
         tick();
      end
      chk("sb_drained", sb.size(), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
